// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter.
// Holds the FSM state encoding, the owner encoding and the latched request format.
// Widths here match the arbiter's default parameters.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W = 64;
    localparam int ARB_DATA_W = 64;
    localparam int ARB_MASK_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Request captured at grant time; the memory side is driven only from this.
    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_MASK_W-1:0] wmask;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the arbiter.
// slave is the arbiter's view; master is the view of the core plus memory around it.
// All handshakes are valid/ready on requests and single-cycle pulses on replies.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_rdata;

    logic              d_req_valid;
    logic              d_req_we;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic [MASK_W-1:0] d_req_wmask;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    logic              busy;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_resp_valid, if_resp_rdata,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
        output d_req_ready, d_resp_valid, d_resp_rdata,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output busy
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_resp_valid, if_resp_rdata,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wmask,
        input  d_req_ready, d_resp_valid, d_resp_rdata,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arb_grant.sv
// One-hot grant selection between the fetch and data requesters.
// Purely combinational, zero latency.
// On conflict: alternate against last_grant when RR_EN, otherwise data wins.
module mem_arb_grant
    import mem_port_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic   if_valid,
    input  logic   d_valid,
    input  owner_t last_grant,
    output logic   grant_if,
    output logic   grant_d
);

    // Pick exactly one requester when any is valid.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_valid && d_valid) begin
            if (RR_EN && (last_grant == OWN_D)) begin
                grant_if = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_if = if_valid;
            grant_d  = d_valid;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one memory port, one transaction in flight.
// Latency: grant same cycle, memory request next cycle, reply forwarded the cycle it arrives.
// Requesters see ready only in IDLE; memory request is held stable until mem_req_ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int MASK_W = ARB_MASK_W,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    state_t   state, state_nx;
    owner_t   owner, owner_nx;
    owner_t   last_grant, last_nx;
    mem_req_t hold, hold_nx;
    logic     grant_if, grant_d;

    // Only arbitrate while idle so a pending requester cannot steal a busy port.
    mem_arb_grant #(.RR_EN(RR_EN)) u_grant (
        .if_valid   (bus.if_req_valid && (state == IDLE)),
        .d_valid    (bus.d_req_valid && (state == IDLE)),
        .last_grant (last_grant),
        .grant_if   (grant_if),
        .grant_d    (grant_d)
    );

    // Registered state; reset leaves last_grant at D so fetch wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_D;
            hold       <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_nx;
            hold       <= hold_nx;
        end
    end

    // Next state and all handshake outputs; everything is forced low while in reset.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last_grant;
        hold_nx  = hold;

        bus.if_req_ready  = 1'b0;
        bus.if_resp_valid = 1'b0;
        bus.if_resp_rdata = '0;
        bus.d_req_ready   = 1'b0;
        bus.d_resp_valid  = 1'b0;
        bus.d_resp_rdata  = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        bus.mem_req_wmask = '0;

        if (!rst) begin
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        bus.if_req_ready = 1'b1;
                        hold_nx.we       = 1'b0;
                        hold_nx.addr     = bus.if_req_addr;
                        hold_nx.wdata    = '0;
                        hold_nx.wmask    = '0;
                        owner_nx         = OWN_IF;
                        last_nx          = OWN_IF;
                        state_nx         = REQ;
                    end else if (grant_d) begin
                        bus.d_req_ready = 1'b1;
                        hold_nx.we      = bus.d_req_we;
                        hold_nx.addr    = bus.d_req_addr;
                        // Reads carry no write payload so the memory never sees a mask on a read.
                        hold_nx.wdata   = bus.d_req_we ? bus.d_req_wdata : '0;
                        hold_nx.wmask   = bus.d_req_we ? bus.d_req_wmask : '0;
                        owner_nx        = OWN_D;
                        last_nx         = OWN_D;
                        state_nx        = REQ;
                    end
                end
                REQ: begin
                    bus.mem_req_valid = 1'b1;
                    bus.mem_req_we    = hold.we;
                    bus.mem_req_addr  = hold.addr[ADDR_W-1:0];
                    bus.mem_req_wdata = hold.wdata[DATA_W-1:0];
                    bus.mem_req_wmask = hold.wmask[MASK_W-1:0];
                    if (bus.mem_req_ready) begin
                        state_nx = RESP;
                    end
                end
                RESP: begin
                    if (bus.mem_resp_valid) begin
                        if (owner == OWN_IF) begin
                            bus.if_resp_valid = 1'b1;
                            bus.if_resp_rdata = bus.mem_resp_rdata;
                        end else begin
                            bus.d_resp_valid = 1'b1;
                            bus.d_resp_rdata = bus.mem_resp_rdata;
                        end
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Pure state decode so the core's stall has no path from the inputs.
    assign bus.busy = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between two requesters: instruction fetch (IF, read-only) and data access (D, read/write).
- Sits between the core's fetch/data request logic and the single memory slave, so the core can run on one RAM port.
- Serialises the two requesters: one outstanding transaction at a time, with fixed or round-robin priority.
- Forwards each reply to the requester that issued it and exports a busy indication so the core can stall.

Parameters:
- ADDR_W, 64, address width of all ports
- DATA_W, 64, data width of all ports
- MASK_W, 8, byte-mask width; must equal DATA_W/8
- RR_EN, 1, 1 = round-robin on conflict; 0 = fixed priority, D over IF

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- if_req_valid  in  1  IF read request pending
- if_req_addr  in  ADDR_W  IF read address, 8-byte aligned
- if_req_ready  out  1  IF request accepted this cycle
- if_resp_valid  out  1  IF read data valid, one-cycle pulse
- if_resp_rdata  out  DATA_W  IF read data
- d_req_valid  in  1  D request pending
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  ADDR_W  D address
- d_req_wdata  in  DATA_W  D write data, already lane-aligned
- d_req_wmask  in  MASK_W  D byte-enable mask
- d_req_ready  out  1  D request accepted this cycle
- d_resp_valid  out  1  D read data returned or write acknowledged, one-cycle pulse
- d_resp_rdata  out  DATA_W  D read data; don't-care on writes
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_req_we  out  1  write enable
- mem_req_addr  out  ADDR_W  address
- mem_req_wdata  out  DATA_W  write data
- mem_req_wmask  out  MASK_W  byte mask; 0 on reads
- mem_resp_valid  in  1  memory reply; returned for both reads and writes
- mem_resp_rdata  in  DATA_W  memory read data
- busy  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, REQ, RESP. A 1-bit owner register records the granted requester (IF or D). A 1-bit last_grant register drives round-robin.
- Reset: state = IDLE, owner = IF, last_grant = D (so IF wins the first conflict under RR). All outputs 0: ready, valid, resp and mem_* buses, busy.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid:
    - RR_EN = 1: grant the requester that is not last_grant.
    - RR_EN = 0: grant D.
  - On grant: assert that requester's req_ready combinationally in the same cycle; latch we/addr/wdata/wmask into a holding register (forced to we = 0, wmask = 0 for IF); set owner and last_grant; go to REQ.
  - If no requester is valid, stay in IDLE.
- REQ:
  - mem_req_valid = 1, driven only from the holding register, so it is stable until accepted.
  - On mem_req_ready = 1, go to RESP. Otherwise hold.
- RESP:
  - mem_req_valid = 0.
  - On mem_resp_valid = 1, pulse the owner's resp_valid combinationally in that cycle, forward mem_resp_rdata to the owner's resp_rdata, and go to IDLE.
  - The non-owner's resp_valid stays 0.
- Minimum latency, request at cycle t:
  - req_ready at t
  - mem_req_valid at t+1
  - with mem_req_ready at t+1 and mem_resp_valid at t+2: resp_valid at t+2
  - next grant possible at t+3
- Requester protocol: valid is held with stable fields until ready. The other requester's valid may stay high indefinitely and is granted on the next IDLE visit. Valid dropped before acceptance is simply never granted.
- Starvation: with RR_EN = 1 and both requesters continuously valid, grants strictly alternate IF, D, IF, D…
- mem_resp_valid in IDLE or REQ: ignored, no output change.
- mem_req_ready outside REQ: ignored.
- Reset mid-transaction: the next cycle is IDLE with all outputs 0. A late mem_resp_valid after reset is dropped.
- busy = (state != IDLE); registered-state decode, so no combinational path from inputs.
- No width arithmetic. Addresses and data pass through unmodified; alignment is the requester's responsibility.

Decomposition:
- Shared package: state enum (IDLE/REQ/RESP), owner enum (OWN_IF/OWN_D), and a packed request struct {we, addr, wdata, wmask} used for the holding register.
- One sub-module, mem_arb_grant: combinational grant logic taking both valids, last_grant and RR_EN, returning a grant_if/grant_d one-hot.

Test Plan:
- Single IF read: if_req_valid = 1, addr 0x1000. Expect if_req_ready at t. mem_req_addr 0x1000, we 0, wmask 0x00 at t+1. Memory replies 0xDEADBEEF_00000013 at t+2; expect if_resp_valid pulse with that data at t+2, d_resp_valid = 0.
- Single D write: addr 0x2008, wdata 0x11223344_55667788, wmask 0xF0. Memory holds mem_req_ready low 3 cycles. Expect mem_req_* stable all 3 cycles, one accept, then d_resp_valid pulse on the ack.
- Conflict:
  - RR_EN = 0: both valid from reset; expect D granted first, IF second.
  - RR_EN = 1: both valid continuously for 6 transactions; expect grant order IF, D, IF, D, IF, D.
- Stray response: assert mem_resp_valid while in IDLE and while in REQ. Expect no resp_valid pulse and no state change.
- Reset mid-flight: rst asserted in RESP. Expect all outputs 0 and busy = 0 next cycle. A following mem_resp_valid produces no requester pulse.
- Back-to-back D reads at 0x0 then 0x8 with zero-wait memory: expect accepts at t and t+3, responses at t+2 and t+5.
